uart_baud_tick_scheduler: RTL and testbench
===========================================

# uart_baud_tick_scheduler

Synthesizable baud-rate scheduler for the UART driver: derives a 16x-oversampled receive tick and a per-bit transmit tick from the single system clock using a fractional phase accumulator (NCO). It sits between the system clock domain and the UART TX/RX engines, which consume single-cycle enables instead of derived clocks. It owns start/stop sequencing and runtime rate/phase reconfiguration through a valid/ready handshake, applied only on bit boundaries so no frame bit is ever truncated.

## Interface
- CLK_FREQUENCY, 100_000_000: system clock frequency in Hz.
- DEFAULT_BAUD, 115_200: baud rate loaded at reset.
- OVERSAMPLE, 16: rx ticks per bit; must be a power of two, ≥ 2.
- ACC_WIDTH, 24: phase accumulator width.
- Derived: OS_W = clog2(OVERSAMPLE); DEFAULT_INC = round(DEFAULT_BAUD·OVERSAMPLE·2^ACC_WIDTH / CLK_FREQUENCY), computed in 64-bit, = 309238 for the defaults.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  level request to run the tick generator.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  configuration accepted this cycle when high with cfg_valid.
- cfg_increment  in  ACC_WIDTH  new accumulator increment.
- cfg_phase  in  OS_W  oversample slot on which tx_tick fires.
- rx_tick  out  1  one-cycle oversample enable.
- tx_tick  out  1  one-cycle bit enable.
- running  out  1  high in RUN and STOPPING.

## Operation
- Reset: state IDLE, acc=0, os_cnt=0, inc=DEFAULT_INC, phase=0, rx_tick=0, tx_tick=0, running=0.
- IDLE: acc and os_cnt held at 0, no ticks. enable=1 sampled → RUN at next edge.
- RUN: every cycle {carry, acc} <= acc + inc (ACC_WIDTH+1-bit sum, carry is the MSB). On carry: rx_tick <= 1, os_cnt <= os_cnt+1 (wraps at OVERSAMPLE), tx_tick <= (os_cnt == phase), evaluated on the pre-increment os_cnt. enable=0 sampled → STOPPING.
- STOPPING: accumulates as in RUN. The cycle a tx_tick is registered → IDLE; that final tx_tick is still emitted. If inc==0 → IDLE at the next edge. enable re-asserted in STOPPING → back to RUN with no discontinuity.
- cfg_ready = (state==IDLE) | (tx_tick & state!=STOPPING), combinational from registered state.
- Accept (cfg_valid & cfg_ready): inc <= cfg_increment, phase <= cfg_phase, acc <= 0, os_cnt <= 0. New rate applies from the next cycle.
- cfg_valid while ready is low: request held by the requester, no register change. cfg_valid must stay stable until accepted.
- inc==0 is legal: no ticks are ever generated.
- Any inc < 2^ACC_WIDTH gives at most one rx_tick per cycle. rx_tick can occur in consecutive cycles only if inc ≥ 2^(ACC_WIDTH-1).
- Output rate: rx_tick frequency = CLK_FREQUENCY·inc/2^ACC_WIDTH. tx_tick = rx_tick/OVERSAMPLE exactly, with no drift between the two.

## Timing
- All outputs are registered, except cfg_ready.
- Latency from enable sampled high at edge E: RUN from E. First carry occurs at the ceil(2^ACC_WIDTH/inc)-th edge after E. rx_tick is high for the cycle following that edge.
- tx_tick is always coincident with an rx_tick.
- rst_n low mid-operation: all state returns to reset values immediately, including inc back to DEFAULT_INC; a pending cfg is lost.
- Simultaneous enable fall and cfg accept on a tx_tick cycle: the config is applied, and the state enters STOPPING with acc=0.
- running falls at the edge entering IDLE.

## Test plan
- Reset values: hold rst_n low, toggle clk → all outputs 0; then release and enable with default inc → mean rx_tick period within ±1 clk of 100e6/1_843_200 ≈ 54.25 clocks over 1000 ticks; tx_tick is every 16th rx_tick.
- Exact rate and phase: cfg inc=4194304 (2^22), phase=0 in IDLE, then enable → rx_tick every 4 clocks starting 4 cycles after RUN entry; tx_tick at RUN cycles 4, 68, 132. With phase=3 → first tx_tick at cycle 16.
- Reconfig in RUN: assert cfg_valid inc=2^21 mid-bit → cfg_ready stays low until the tx_tick cycle; after acceptance, rx_tick period is 8 clocks and tx_tick period is 128 clocks.
- Graceful stop: drop enable 10 clocks after a tx_tick with inc=2^22 → exactly one more tx_tick at +64 from the previous one, running=0 the cycle after, then no further ticks.
- Zero increment: cfg inc=0 in IDLE, enable for 1000 clocks → no ticks. Drop enable → IDLE within 2 clocks.
- Async reset mid-RUN: pulse rst_n low between clock edges → ticks drop immediately; after release, enable → rate reverts to DEFAULT_INC.

Source files
------------

// File: rtl/uart_baud_tick_scheduler.sv
// uart_baud_tick_scheduler: NCO-based 16x rx tick and per-bit tx tick generator with bit-aligned reconfiguration
module uart_baud_tick_scheduler #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int DEFAULT_BAUD  = 115_200,
  parameter int OVERSAMPLE    = 16,
  parameter int ACC_WIDTH     = 24,
  localparam int OS_W         = $clog2(OVERSAMPLE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [ACC_WIDTH-1:0] cfg_increment,
  input  logic [OS_W-1:0]      cfg_phase,
  output logic                 rx_tick,
  output logic                 tx_tick,
  output logic                 running
);
  localparam logic [ACC_WIDTH-1:0] DEFAULT_INC = ACC_WIDTH'((((64'(DEFAULT_BAUD) * 64'(OVERSAMPLE)) << ACC_WIDTH) + 64'(CLK_FREQUENCY) / 2) / 64'(CLK_FREQUENCY));
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOPPING} state_t;
  state_t                r_state, w_next;
  logic [ACC_WIDTH-1:0]  r_acc, r_inc;
  logic [OS_W-1:0]       r_os_cnt, r_phase;
  logic                  r_rx, r_tx, r_running;
  logic [ACC_WIDTH:0]    w_sum;
  logic                  w_active, w_fire, w_tx_fire, w_accept, w_clear;
  // Carry detection, handshake and next state; a stop only completes on a tx tick so no bit is cut short
  always_comb begin
    w_sum     = {1'b0, r_acc} + {1'b0, r_inc};
    w_active  = r_state != S_IDLE;
    w_fire    = w_active & w_sum[ACC_WIDTH];
    w_tx_fire = w_fire & (r_os_cnt == r_phase);
    cfg_ready = (r_state == S_IDLE) | (r_tx & (r_state != S_STOPPING));
    w_accept  = cfg_valid & cfg_ready;
    w_next    = enable ? S_RUN :
                (r_state == S_RUN) ? S_STOPPING :
                (r_state == S_STOPPING && r_inc != '0 && !w_tx_fire) ? S_STOPPING : S_IDLE;
    w_clear   = w_accept | (w_next == S_IDLE) | !w_active;
  end
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  // Accumulator, oversample counter, tick outputs and configuration; an accepted config restarts the bit phase
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_acc     <= '0;
      r_os_cnt  <= '0;
      r_inc     <= DEFAULT_INC;
      r_phase   <= '0;
      r_rx      <= 1'b0;
      r_tx      <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_acc     <= w_clear ? '0 : w_sum[ACC_WIDTH-1:0];
      r_os_cnt  <= w_clear ? '0 : r_os_cnt + OS_W'(w_fire);
      r_rx      <= w_fire & !w_accept;
      r_tx      <= w_tx_fire & !w_accept;
      r_running <= w_next != S_IDLE;
      if (w_accept) begin
        r_inc   <= cfg_increment;
        r_phase <= cfg_phase;
      end
    end
  assign rx_tick = r_rx;
  assign tx_tick = r_tx;
  assign running = r_running;
endmodule

// File: tb/tb_uart_baud_tick_scheduler.sv
// tb_uart_baud_tick_scheduler: directed checks of rate, phase, reconfiguration, stop and reset behaviour
module tb_uart_baud_tick_scheduler;
  localparam int AW = 24;
  logic          clk = 1'b0, rst_n = 1'b0, enable = 1'b0, cfg_valid = 1'b0;
  logic          cfg_ready, rx_tick, tx_tick, running;
  logic [AW-1:0] cfg_increment = '0;
  logic [3:0]    cfg_phase = '0;
  int            cyc = 0, total = 0, bad = 0;
  always #5 clk = ~clk;
  uart_baud_tick_scheduler dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_increment(cfg_increment), .cfg_phase(cfg_phase), .rx_tick(rx_tick), .tx_tick(tx_tick), .running(running)
  );
  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic observe(input int n, input int ph, output int nrx, ntx, frx, lrx, t0, t1, t2, err);
    nrx = 0; ntx = 0; frx = -1; lrx = -1; t0 = -1; t1 = -1; t2 = -1; err = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (tx_tick && (!rx_tick || (ph >= 0 && nrx % 16 != ph))) err++;
      if (tx_tick) begin
        if (ntx == 0) t0 = cyc;
        else if (ntx == 1) t1 = cyc;
        else if (ntx == 2) t2 = cyc;
        ntx++;
      end
      if (rx_tick) begin
        if (nrx == 0) frx = cyc;
        lrx = cyc;
        nrx++;
      end
    end
  endtask
  task automatic stop_idle();
    enable = 1'b0;
    for (int i = 0; i < 3000 && running; i++) step();
    chk("stop_to_idle", running, 0);
  endtask
  task automatic cfg_idle(input logic [AW-1:0] inc, input logic [3:0] ph);
    cfg_increment = inc;
    cfg_phase = ph;
    cfg_valid = 1'b1;
    chk("cfg_ready_idle", cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
  endtask
  task automatic cfg_run(input logic [AW-1:0] inc, input logic [3:0] ph, output int a);
    cfg_increment = inc;
    cfg_phase = ph;
    cfg_valid = 1'b1;
    a = -1;
    for (int i = 0; i < 2000; i++) begin
      if (cfg_ready) begin
        a = cyc;
        chk("cfg_ready_on_tx", tx_tick, 1);
        break;
      end
      step();
    end
    chk("cfg_accept_seen", a >= 0, 1);
    step();
    cfg_valid = 1'b0;
  endtask
  initial begin
    int k, nrx, ntx, frx, lrx, t0, t1, t2, err, a, tp;
    repeat (3) step();
    chk("rst_rx", rx_tick, 0);
    chk("rst_tx", tx_tick, 0);
    chk("rst_running", running, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    rst_n = 1'b1;
    step();
    k = cyc;
    enable = 1'b1;
    observe(54300, 0, nrx, ntx, frx, lrx, t0, t1, t2, err);
    chk("dflt_first_rx", frx, k + 56);
    chk("dflt_first_tx", t0, k + 56);
    chk("dflt_rx_count", nrx, 1000);
    chk("dflt_mean_period", (longint'(lrx - frx) * 100 >= 5325 * longint'(nrx - 1)) &&
                            (longint'(lrx - frx) * 100 <= 5525 * longint'(nrx - 1)), 1);
    chk("dflt_tx_count", ntx, (nrx + 15) / 16);
    chk("dflt_tx_align", err, 0);
    stop_idle();
    cfg_idle(24'h400000, 4'd0);
    k = cyc;
    enable = 1'b1;
    observe(140, 0, nrx, ntx, frx, lrx, t0, t1, t2, err);
    chk("p0_first_rx", frx, k + 5);
    chk("p0_rx_count", nrx, 34);
    chk("p0_last_rx", lrx, k + 137);
    chk("p0_tx0", t0, k + 5);
    chk("p0_tx1", t1, k + 69);
    chk("p0_tx2", t2, k + 133);
    chk("p0_tx_align", err, 0);
    stop_idle();
    cfg_idle(24'h400000, 4'd3);
    k = cyc;
    enable = 1'b1;
    observe(20, 3, nrx, ntx, frx, lrx, t0, t1, t2, err);
    chk("p3_tx0", t0, k + 17);
    chk("p3_tx_count", ntx, 1);
    chk("p3_tx_align", err, 0);
    tp = t0;
    repeat (7) step();
    cfg_run(24'h200000, 4'd0, a);
    chk("rc_accept_cycle", a, tp + 64);
    observe(279, 0, nrx, ntx, frx, lrx, t0, t1, t2, err);
    chk("rc_first_rx", frx, a + 9);
    chk("rc_rx_count", nrx, 34);
    chk("rc_last_rx", lrx, a + 273);
    chk("rc_tx0", t0, a + 9);
    chk("rc_tx1", t1, a + 137);
    chk("rc_tx2", t2, a + 265);
    chk("rc_tx_align", err, 0);
    cfg_run(24'h400000, 4'd0, a);
    observe(4, 0, nrx, ntx, frx, lrx, t0, t1, t2, err);
    chk("gs_tx_before_stop", t0, a + 5);
    tp = cyc;
    repeat (10) step();
    enable = 1'b0;
    step();
    chk("gs_running_stopping", running, 1);
    observe(54, -1, nrx, ntx, frx, lrx, t0, t1, t2, err);
    chk("gs_final_tx_count", ntx, 1);
    chk("gs_final_tx_cycle", t0, tp + 64);
    chk("gs_rx_count", nrx, 14);
    chk("gs_last_rx", lrx, tp + 64);
    chk("gs_running_after", running, 0);
    observe(50, -1, nrx, ntx, frx, lrx, t0, t1, t2, err);
    chk("gs_idle_rx", nrx, 0);
    chk("gs_idle_tx", ntx, 0);
    cfg_idle(24'h000000, 4'd0);
    enable = 1'b1;
    observe(1000, -1, nrx, ntx, frx, lrx, t0, t1, t2, err);
    chk("z_rx_count", nrx, 0);
    chk("z_tx_count", ntx, 0);
    chk("z_running", running, 1);
    chk("z_cfg_ready_run", cfg_ready, 0);
    enable = 1'b0;
    repeat (2) step();
    chk("z_idle_in_2", running, 0);
    cfg_idle(24'h400000, 4'd0);
    enable = 1'b1;
    observe(5, 0, nrx, ntx, frx, lrx, t0, t1, t2, err);
    chk("ar_rx_before", rx_tick, 1);
    chk("ar_tx_before", tx_tick, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_rx_dropped", rx_tick, 0);
    chk("ar_tx_dropped", tx_tick, 0);
    chk("ar_running_dropped", running, 0);
    #1 rst_n = 1'b1;
    k = cyc;
    observe(924, 0, nrx, ntx, frx, lrx, t0, t1, t2, err);
    chk("ar_first_rx", frx, k + 56);
    chk("ar_first_tx", t0, k + 56);
    chk("ar_rx_count", nrx, 17);
    chk("ar_rx17", lrx, k + 924);
    chk("ar_tx_align", err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
